// File: rtl/lsu_fence_ctrl.sv
// Per-warp outstanding memory request tracker with a single-fence sequencer.
// Issue is back-pressured at DEPTH outstanding requests or while that warp is fenced.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no fence in flight; a new fence is accepted
// DRAIN | fence latched; requests to fence_wid are blocked until its count is 0
// DONE  | completion presented to the scheduler; held until fence_done_ready_i
module lsu_fence_ctrl #(
   parameter int NUM_WARP = 8,
   parameter int WID_W    = $clog2(NUM_WARP),
   parameter int DEPTH    = 4,
   parameter int CNT_W    = $clog2(DEPTH+1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid_i,
   input  logic [WID_W-1:0]    req_wid_i,
   output logic                req_ready_o,
   input  logic                rsp_valid_i,
   input  logic [WID_W-1:0]    rsp_wid_i,
   input  logic                fence_valid_i,
   input  logic [WID_W-1:0]    fence_wid_i,
   output logic                fence_ready_o,
   output logic                fence_done_valid_o,
   output logic [WID_W-1:0]    fence_done_wid_o,
   input  logic                fence_done_ready_i,
   output logic [NUM_WARP-1:0] busy_o,
   output logic [NUM_WARP-1:0] full_o,
   output logic                underflow_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [WID_W-1:0]    fence_wid;
   logic [CNT_W-1:0]    cnt [NUM_WARP];
   logic [NUM_WARP-1:0] inc_vec;
   logic [NUM_WARP-1:0] dec_vec;
   logic                req_fire;
   logic                fence_fire;
   logic                fence_block;
   logic                underflow_nxt;

   always_comb begin
      busy_o = '0;
      full_o = '0;
      for (int w = 0; w < NUM_WARP; w++) begin
         busy_o[w] = (cnt[w] != '0);
         full_o[w] = (cnt[w] == CNT_W'(DEPTH));
      end
   end

   // The fence blocks its own warp from DRAIN until completion is consumed.
   assign fence_block   = (state != IDLE) && (fence_wid == req_wid_i);
   assign req_ready_o   = !full_o[req_wid_i] && !fence_block;
   assign req_fire      = req_valid_i && req_ready_o;
   assign fence_ready_o = (state == IDLE);
   assign fence_fire    = fence_valid_i && fence_ready_o;

   assign fence_done_valid_o = (state == DONE);
   assign fence_done_wid_o   = fence_wid;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int w = 0; w < NUM_WARP; w++) begin
         inc_vec[w] = req_fire && (req_wid_i == WID_W'(w));
         dec_vec[w] = rsp_valid_i && (rsp_wid_i == WID_W'(w)) && (cnt[w] != '0);
      end
   end

   assign underflow_nxt = rsp_valid_i && (cnt[rsp_wid_i] == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WARP; w++) cnt[w] <= '0;
         underflow_o <= 1'b0;
      end else begin
         for (int w = 0; w < NUM_WARP; w++) begin
            if (inc_vec[w] && !dec_vec[w]) cnt[w] <= cnt[w] + CNT_W'(1);
            else if (dec_vec[w] && !inc_vec[w]) cnt[w] <= cnt[w] - CNT_W'(1);
         end
         underflow_o <= underflow_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fence_fire) state_nxt = DRAIN;
         DRAIN:   if (cnt[fence_wid] == '0) state_nxt = DONE;
         DONE:    if (fence_done_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fence_wid <= '0;
      end else begin
         state <= state_nxt;
         if (fence_fire) fence_wid <= fence_wid_i;
      end
   end

endmodule

// File: tb/tb_lsu_fence_ctrl.sv
// Directed bench for lsu_fence_ctrl: counting, saturation, fences, underflow, reset.
module tb_lsu_fence_ctrl;

   localparam int NUM_WARP = 8;
   localparam int WID_W    = 3;
   localparam int DEPTH    = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                req_valid_i;
   logic [WID_W-1:0]    req_wid_i;
   logic                req_ready_o;
   logic                rsp_valid_i;
   logic [WID_W-1:0]    rsp_wid_i;
   logic                fence_valid_i;
   logic [WID_W-1:0]    fence_wid_i;
   logic                fence_ready_o;
   logic                fence_done_valid_o;
   logic [WID_W-1:0]    fence_done_wid_o;
   logic                fence_done_ready_i;
   logic [NUM_WARP-1:0] busy_o;
   logic [NUM_WARP-1:0] full_o;
   logic                underflow_o;

   int n_checks = 0;
   int n_fail   = 0;

   lsu_fence_ctrl #(.NUM_WARP(NUM_WARP), .DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid_i        (req_valid_i),
      .req_wid_i          (req_wid_i),
      .req_ready_o        (req_ready_o),
      .rsp_valid_i        (rsp_valid_i),
      .rsp_wid_i          (rsp_wid_i),
      .fence_valid_i      (fence_valid_i),
      .fence_wid_i        (fence_wid_i),
      .fence_ready_o      (fence_ready_o),
      .fence_done_valid_o (fence_done_valid_o),
      .fence_done_wid_o   (fence_done_wid_o),
      .fence_done_ready_i (fence_done_ready_i),
      .busy_o             (busy_o),
      .full_o             (full_o),
      .underflow_o        (underflow_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      req_valid_i = 1'b0; req_wid_i = '0;
      rsp_valid_i = 1'b0; rsp_wid_i = '0;
      fence_valid_i = 1'b0; fence_wid_i = '0;
      fence_done_ready_i = 1'b0;
      #12;
      check_eq("rst_busy", 32'(busy_o), 32'h0);
      check_eq("rst_full", 32'(full_o), 32'h0);
      check_eq("rst_underflow", 32'(underflow_o), 32'h0);
      check_eq("rst_done_valid", 32'(fence_done_valid_o), 32'h0);
      check_eq("rst_done_wid", 32'(fence_done_wid_o), 32'h0);
      check_eq("rst_req_ready", 32'(req_ready_o), 32'h1);
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("idle_fence_ready", 32'(fence_ready_o), 32'h1);

      // 1: fill warp 2
      req_valid_i = 1'b1; req_wid_i = 3'd2;
      repeat (DEPTH) tick();
      req_valid_i = 1'b0;
      settle();
      check_eq("t1_full", 32'(full_o), 32'h04);
      check_eq("t1_busy", 32'(busy_o), 32'h04);
      check_eq("t1_ready_w2", 32'(req_ready_o), 32'h0);
      req_wid_i = 3'd3; settle();
      check_eq("t1_ready_w3", 32'(req_ready_o), 32'h1);

      // 2: at full, req cannot fire so the response decrements; at 3, req+rsp holds
      req_valid_i = 1'b1; req_wid_i = 3'd2; rsp_valid_i = 1'b1; rsp_wid_i = 3'd2;
      settle();
      check_eq("t2_ready_full", 32'(req_ready_o), 32'h0);
      tick();
      check_eq("t2_full_after_rsp", 32'(full_o), 32'h00);
      check_eq("t2_ready_at3", 32'(req_ready_o), 32'h1);
      tick();
      rsp_valid_i = 1'b0;
      settle();
      check_eq("t2_hold_full", 32'(full_o), 32'h00);
      check_eq("t2_hold_busy", 32'(busy_o), 32'h04);
      tick();
      req_valid_i = 1'b0;
      settle();
      check_eq("t2_refull", 32'(full_o), 32'h04);
      rsp_valid_i = 1'b1; rsp_wid_i = 3'd2;
      repeat (DEPTH) tick();
      rsp_valid_i = 1'b0;
      settle();
      check_eq("t2_drained", 32'(busy_o), 32'h00);
      check_eq("t2_no_underflow", 32'(underflow_o), 32'h0);

      // 3: fence to an idle warp
      fence_valid_i = 1'b1; fence_wid_i = 3'd5;
      settle();
      check_eq("t3_fence_ready", 32'(fence_ready_o), 32'h1);
      tick();
      fence_valid_i = 1'b0;
      settle();
      check_eq("t3_t1_done", 32'(fence_done_valid_o), 32'h0);
      check_eq("t3_t1_fence_ready", 32'(fence_ready_o), 32'h0);
      tick();
      check_eq("t3_t2_done", 32'(fence_done_valid_o), 32'h1);
      check_eq("t3_t2_wid", 32'(fence_done_wid_o), 32'h5);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t3_hold_valid", 32'(fence_done_valid_o), 32'h1);
         check_eq("t3_hold_wid", 32'(fence_done_wid_o), 32'h5);
      end
      fence_done_ready_i = 1'b1;
      tick();
      fence_done_ready_i = 1'b0;
      settle();
      check_eq("t3_back_idle", 32'(fence_ready_o), 32'h1);
      check_eq("t3_done_clear", 32'(fence_done_valid_o), 32'h0);

      // 4: fence warp 1 with 3 outstanding
      req_valid_i = 1'b1; req_wid_i = 3'd1;
      repeat (3) tick();
      req_valid_i = 1'b0;
      fence_valid_i = 1'b1; fence_wid_i = 3'd1;
      tick();
      fence_valid_i = 1'b0;
      req_valid_i = 1'b1; req_wid_i = 3'd1;
      settle();
      check_eq("t4_w1_blocked", 32'(req_ready_o), 32'h0);
      req_wid_i = 3'd0;
      settle();
      check_eq("t4_w0_ready", 32'(req_ready_o), 32'h1);
      tick();
      req_valid_i = 1'b0;
      settle();
      check_eq("t4_busy", 32'(busy_o), 32'h03);
      rsp_valid_i = 1'b1; rsp_wid_i = 3'd1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_eq("t4_no_done_yet", 32'(fence_done_valid_o), 32'h0);
         tick();
      end
      rsp_valid_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2 && !seen; i++) begin
         settle();
         if (fence_done_valid_o) seen = 1'b1;
         else tick();
      end
      check_eq("t4_done_seen", 32'(seen), 32'h1);
      check_eq("t4_done_wid", 32'(fence_done_wid_o), 32'h1);
      check_eq("t4_busy_w1_clear", 32'(busy_o), 32'h01);
      fence_done_ready_i = 1'b1;
      rsp_valid_i = 1'b1; rsp_wid_i = 3'd0;
      tick();
      fence_done_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      settle();
      check_eq("t4_idle", 32'(fence_ready_o), 32'h1);
      check_eq("t4_all_idle", 32'(busy_o), 32'h00);

      // 5: underflow on empty warp 6
      rsp_valid_i = 1'b1; rsp_wid_i = 3'd6;
      settle();
      check_eq("t5_uf_not_yet", 32'(underflow_o), 32'h0);
      tick();
      rsp_valid_i = 1'b0;
      settle();
      check_eq("t5_uf_pulse", 32'(underflow_o), 32'h1);
      check_eq("t5_busy", 32'(busy_o), 32'h00);
      check_eq("t5_no_wrap_full", 32'(full_o), 32'h00);
      tick();
      check_eq("t5_uf_drop", 32'(underflow_o), 32'h0);
      check_eq("t5_busy_after", 32'(busy_o), 32'h00);

      // 6: reset during DRAIN
      req_valid_i = 1'b1; req_wid_i = 3'd1;
      repeat (2) tick();
      req_valid_i = 1'b0;
      fence_valid_i = 1'b1; fence_wid_i = 3'd1;
      tick();
      fence_valid_i = 1'b0;
      settle();
      check_eq("t6_drain", 32'(fence_ready_o), 32'h0);
      check_eq("t6_busy_pre", 32'(busy_o), 32'h02);
      #1 rst_n = 1'b0;
      #1;
      check_eq("t6_rst_busy", 32'(busy_o), 32'h00);
      check_eq("t6_rst_done", 32'(fence_done_valid_o), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      req_wid_i = 3'd1;
      settle();
      check_eq("t6_fence_ready", 32'(fence_ready_o), 32'h1);
      check_eq("t6_req_ready_w1", 32'(req_ready_o), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t6_no_done", 32'(fence_done_valid_o), 32'h0);
         check_eq("t6_busy_zero", 32'(busy_o), 32'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
